det_frame_arbiter: RTL and testbench
====================================

# det_frame_arbiter

Round-robin scheduler that shares one serial sequence detector (single-bit input `x`, single-bit output `y`, sync reset) among `N_REQ` requesters. Each granted requester's `FRAME_LEN`-bit frame is cleared into, shifted through and drained from the detector. The number of detections is returned with a one-cycle `done` pulse. The block sits between the requesting blocks and the detector instance, and it owns the detector's `x` and `reset`.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `FRAME_LEN`, 8: bits per frame (2..32).
- `CNT_W`, 4: width of the hit counter.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in `N_REQ`: request per requester. It is level, held until `done` with own `gnt`.
- `frame_data` in `N_REQ*FRAME_LEN`: frame of requester i in slice [i*FRAME_LEN +: FRAME_LEN]. It is stable while `req` is high.
- `gnt` out `N_REQ`: one-hot grant, registered.
- `done` out 1: one-cycle pulse marking end of the granted transaction.
- `hit_cnt` out `CNT_W`: detections in the last completed frame. Valid with `done`, held until the next `done`.
- `det_x` out 1: serial bit to the detector.
- `det_rst` out 1: synchronous reset to the detector.
- `det_y` in 1: detector output, registered (Moore). It reflects the bit presented on `det_x` one cycle earlier.

## Operation
- State machine: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- **IDLE**
  - `gnt`=0.
  - If any `req`, pick the first set bit searching upward (wrapping) from `last+1`, where `last` is the previously granted index.
  - Register the one-hot `gnt` and go to CLEAR.
  - Otherwise stay in IDLE.
- **CLEAR**
  - `det_rst`=1 for one cycle.
  - Accumulator cleared to 0.
  - Bit index set to `FRAME_LEN-1`. Go to SHIFT.
- **SHIFT**
  - `det_x` = frame bit [index], MSB first.
  - Index decrements each cycle. After index 0 has been presented, go to DRAIN.
  - Stays `FRAME_LEN` cycles.
- **DRAIN**
  - One cycle. `det_x`=0.
- **Counting**
  - `det_y` is sampled in every SHIFT cycle except the first, and in the DRAIN cycle. That is exactly `FRAME_LEN` samples.
  - Each sample of 1 increments the accumulator, saturating at 2^`CNT_W`-1.
- **DONE**
  - `done`=1 for one cycle and `hit_cnt` is loaded from the accumulator.
  - `gnt` stays asserted this cycle. `last` is updated to the granted index.
  - Go to IDLE.
- `det_rst`=0 and `det_x`=0 in all states except those stated above.
- `req` changes of non-granted requesters have no effect until the next IDLE.
- Without the abort option, a granted requester dropping `req` mid-frame is ignored and the frame completes.

## Timing
- Reset values: state IDLE, `gnt`=0, `done`=0, `hit_cnt`=0, `det_x`=0, `det_rst`=1, `last`=`N_REQ-1` (so requester 0 wins first).
- `reset` asserted mid-transaction: the next cycle is IDLE with the reset values, and no `done` is issued.
- Latency:
  - `req` sampled in IDLE at cycle 0.
  - `gnt` visible at cycle 1 (CLEAR).
  - SHIFT runs cycles 2..`FRAME_LEN`+1.
  - DRAIN is at cycle `FRAME_LEN`+2.
  - DONE is at cycle `FRAME_LEN`+3.
- Transaction period is `FRAME_LEN`+4 cycles, including one IDLE cycle between back-to-back grants.
- Simultaneous requests are arbitrated only in IDLE. Rotation is strictly fair.

## Configuration
- `DET_ARB_ABORT_EN` defined:
  - If the granted `req` is low in CLEAR, SHIFT or DRAIN, the next state is IDLE.
  - No `done` is issued, `hit_cnt` is unchanged and `det_rst` is pulsed in that IDLE cycle.
  - `last` is updated to the aborted index.
- `DET_ARB_ABORT_EN` undefined: the frame always completes as described under Operation.

## Structure
- Package `det_arb_pkg` holds:
  - the state enum (IDLE, CLEAR, SHIFT, DRAIN, DONE);
  - the default `N_REQ`/`FRAME_LEN`/`CNT_W` constants;
  - the index-width function (clog2).
- Sub-module `rr_pick`: a combinational round-robin picker with inputs `req` and `last` and a one-hot output. It is reused by later arbiters.

## Test plan
The bench uses a detector model for overlapping "101", `N_REQ`=4, `FRAME_LEN`=8, `CNT_W`=4.
- **Single request:** `req`=0001, frame 8'b10101010.
  - `gnt`=0001 at cycle 1, `det_x` sequence 1,0,1,0,1,0,1,0.
  - `done` at cycle 11 with `hit_cnt`=3.
- **Rotation:** `req`=1111 held.
  - Grant order 0001, 0010, 0100, 1000, 0001.
  - Grants are spaced 12 cycles apart.
- **No hits:** frame 8'b11111111 → `hit_cnt`=0. A following frame 8'b00101000 → `hit_cnt`=1.
- **Saturation:** `FRAME_LEN`=16, `CNT_W`=2, frame 16'hAAAA (7 hits) → `hit_cnt`=3.
- **Reset mid-frame:** assert `reset` during SHIFT cycle 4.
  - Next cycle: `gnt`=0, `det_rst`=1, no `done`.
  - After release, requester 0 is re-granted first.
- **Drop request, compiled both ways:** the granted requester drops `req` in SHIFT.
  - With `DET_ARB_ABORT_EN`: IDLE next cycle, no `done`, `hit_cnt` unchanged.
  - Without it: the full frame completes and `done` is issued.

Source files
------------

// File: rtl/det_arb_pkg.sv
// Shared state encoding, default sizes and index-width helper for the
// detector frame arbiter and its round-robin picker.
package det_arb_pkg;

  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_FRAME_LEN = 8;
  localparam int unsigned DEF_CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/det_frame_arbiter_if.sv
// Requester-side bus of the detector frame arbiter: level requests with
// their frames in, one-hot grant and per-frame hit count back.
interface det_frame_arbiter_if
  import det_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) ();

  logic [N_REQ-1:0]           req;
  logic [N_REQ*FRAME_LEN-1:0] frame_data;
  logic [N_REQ-1:0]           gnt;
  logic                       done;
  logic [CNT_W-1:0]           hit_cnt;

  modport master (output req, frame_data, input gnt, done, hit_cnt);
  modport slave  (input req, frame_data, output gnt, done, hit_cnt);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot of the first set request found
// searching upward (with wrap) from last+1.
module rr_pick
  import det_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] gnt_c
);

  logic [IW-1:0] k;

  // Scan farthest to nearest so the nearest set request is written last.
  always_comb begin
    gnt_c = '0;
    k     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = IW'((int'(last) + i) % int'(N_REQ));
      if (req[k]) begin
        gnt_c    = '0;
        gnt_c[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/det_frame_arbiter.sv
// Round-robin sharing of one serial sequence detector among N_REQ requesters.
// Optional abort on a dropped request: DET_ARB_ABORT_EN.
module det_frame_arbiter
  import det_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  det_frame_arbiter_if.slave bus,
  output logic               det_x,
  output logic               det_rst,
  input  logic               det_y
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned BW = idx_w(FRAME_LEN);

  state_e               state_q, state_n;
  logic [N_REQ-1:0]     gnt_q, gnt_n, pick_c;
  logic [IW-1:0]        last_q, last_n, gidx_q, gidx_n, pick_idx_c;
  logic [BW-1:0]        idx_q, idx_n;
  logic [CNT_W-1:0]     acc_q, acc_n, hit_q, hit_n;
  logic                 done_q, done_n, det_x_n, det_rst_n;
  logic                 sample_c;
  logic [FRAME_LEN-1:0] frames [N_REQ];
  logic [FRAME_LEN-1:0] frame_c;

  for (genvar i = 0; i < N_REQ; i++) begin : g_frames
    assign frames[i] = bus.frame_data[i*FRAME_LEN +: FRAME_LEN];
  end
  assign frame_c = frames[gidx_q];

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .gnt_c (pick_c)
  );

  always_comb begin
    pick_idx_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_c[i]) pick_idx_c = IW'(i);
    end
  end

  // det_y lags det_x by one cycle: skip the first SHIFT, include DRAIN.
  assign sample_c = ((state_q == ST_SHIFT) && (idx_q != BW'(FRAME_LEN-1))) ||
                    (state_q == ST_DRAIN);

  always_comb begin
    state_n   = state_q;
    gnt_n     = gnt_q;
    last_n    = last_q;
    gidx_n    = gidx_q;
    idx_n     = idx_q;
    acc_n     = acc_q;
    hit_n     = hit_q;
    done_n    = 1'b0;
    det_x_n   = 1'b0;
    det_rst_n = 1'b0;

    if (sample_c && det_y && (acc_q != '1)) acc_n = acc_q + CNT_W'(1);

    // Registered outputs are computed for the state being entered.
    case (state_q)
      ST_IDLE: begin
        gnt_n = '0;
        if (|bus.req) begin
          gnt_n     = pick_c;
          gidx_n    = pick_idx_c;
          det_rst_n = 1'b1;
          state_n   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        acc_n   = '0;
        idx_n   = BW'(FRAME_LEN-1);
        det_x_n = frame_c[FRAME_LEN-1];
        state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (idx_q == '0) begin
          state_n = ST_DRAIN;
        end else begin
          idx_n   = idx_q - BW'(1);
          det_x_n = frame_c[idx_n];
        end
      end
      ST_DRAIN: begin
        done_n  = 1'b1;
        hit_n   = acc_n;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        gnt_n   = '0;
        last_n  = gidx_q;
        state_n = ST_IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

`ifdef DET_ARB_ABORT_EN
    // Granted requester withdrew: abandon the frame and re-clear the detector.
    if (((state_q == ST_CLEAR) || (state_q == ST_SHIFT) || (state_q == ST_DRAIN)) &&
        !bus.req[gidx_q]) begin
      state_n   = ST_IDLE;
      gnt_n     = '0;
      last_n    = gidx_q;
      hit_n     = hit_q;
      done_n    = 1'b0;
      det_x_n   = 1'b0;
      det_rst_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N_REQ-1);
      gidx_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      hit_q   <= '0;
      done_q  <= 1'b0;
      det_x   <= 1'b0;
      det_rst <= 1'b1;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      last_q  <= last_n;
      gidx_q  <= gidx_n;
      idx_q   <= idx_n;
      acc_q   <= acc_n;
      hit_q   <= hit_n;
      done_q  <= done_n;
      det_x   <= det_x_n;
      det_rst <= det_rst_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.hit_cnt = hit_q;

endmodule

// File: tb/tb_det_frame_arbiter.sv
// Randomized self-checking bench: overlapping "101" detector model behind the
// arbiter, expectations from a round-robin/pattern-count reference.
module tb_det_frame_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  det_frame_arbiter_if #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(4)) bus ();
  det_frame_arbiter_if #(.N_REQ(4), .FRAME_LEN(16), .CNT_W(2)) bus_s ();

  logic det_x, det_rst, det_y;
  logic det_x_s, det_rst_s, det_y_s;
  logic [1:0] hist, hist_s;

  det_frame_arbiter #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .det_x(det_x), .det_rst(det_rst), .det_y(det_y)
  );

  det_frame_arbiter #(.N_REQ(4), .FRAME_LEN(16), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s),
    .det_x(det_x_s), .det_rst(det_rst_s), .det_y(det_y_s)
  );

  // Moore detector for overlapping "101" with synchronous reset.
  always_ff @(posedge clk) begin
    if (det_rst) begin
      hist  <= 2'b00;
      det_y <= 1'b0;
    end else begin
      hist  <= {hist[0], det_x};
      det_y <= ({hist, det_x} == 3'b101);
    end
  end

  always_ff @(posedge clk) begin
    if (det_rst_s) begin
      hist_s  <= 2'b00;
      det_y_s <= 1'b0;
    end else begin
      hist_s  <= {hist_s[0], det_x_s};
      det_y_s <= ({hist_s, det_x_s} == 3'b101);
    end
  end

  int checks   = 0;
  int failures = 0;
  int last_m   = 3;
  int hit_m    = 0;
  logic [7:0] frm [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int count101(input logic [31:0] f, input int len);
    int n = 0;
    for (int i = len - 1; i >= 2; i--) begin
      logic [4:0] a, b, c;
      a = 5'(i); b = 5'(i - 1); c = 5'(i - 2);
      if (f[a] && !f[b] && f[c]) n++;
    end
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  function automatic int rr_winner(input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      int k = (last_m + i) % 4;
      if (r[k[1:0]]) return k;
    end
    return -1;
  endfunction

  // One transaction from an IDLE cycle (cycle 0) through DONE (cycle 11).
  task automatic run_frame(input logic [3:0] reqv, input int drop_cyc, input bit toggle);
    int w, exp_hit;
    logic [7:0] fr;
    logic [3:0] oh;
    @(negedge clk);
    check_eq("idle_gnt", bus.gnt, 0);
    bus.frame_data = {frm[3], frm[2], frm[1], frm[0]};
    bus.req = reqv;
    w  = rr_winner(reqv);
    oh = 4'(32'd1 << w);
    fr = frm[w[1:0]];
    exp_hit = sat(count101({24'h0, fr}, 8), 4);
    @(negedge clk);
    check_eq("gnt", bus.gnt, oh);
    check_eq("clr_rst", det_rst, 1);
    check_eq("hold_hit", bus.hit_cnt, hit_m);
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
`ifdef DET_ARB_ABORT_EN
      if (drop_cyc != 0 && c == drop_cyc + 1) begin
        check_eq("abort_gnt", bus.gnt, 0);
        check_eq("abort_rst", det_rst, 1);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_hit", bus.hit_cnt, hit_m);
        last_m = w;
        return;
      end
`endif
      if (c <= 9) begin
        logic [2:0] bi;
        bi = 3'(9 - c);
        check_eq("det_x", det_x, fr[bi]);
      end else if (c == 10) begin
        check_eq("drain_x", det_x, 0);
      end
      check_eq("done", bus.done, (c == 11));
      check_eq("gnt_hold", bus.gnt, oh);
      if (c == 11) check_eq("hit", bus.hit_cnt, exp_hit);
      if (c == drop_cyc) bus.req = '0;
      else if (toggle && c == 5) bus.req = (4'($urandom) & ~oh) | oh;
    end
    hit_m  = exp_hit;
    last_m = w;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit got;
    reset = 1'b1;
    bus.req = '0;
    bus.frame_data = '0;
    bus_s.req = '0;
    bus_s.frame_data = '0;
    for (int i = 0; i < 4; i++) frm[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", bus.gnt, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_hit", bus.hit_cnt, 0);
    check_eq("rst_det_x", det_x, 0);
    check_eq("rst_det_rst", det_rst, 1);
    check_eq("rst_s_gnt", bus_s.gnt, 0);
    reset = 1'b0;

    // Saturation on the 16-bit frame, 2-bit counter instance.
    @(negedge clk);
    bus_s.frame_data = {48'h0, 16'hAAAA};
    bus_s.req = 4'b0001;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (bus_s.done) got = 1'b1;
    end
    check_eq("sat_latency", cyc, 16 + 3);
    check_eq("sat_hit", bus_s.hit_cnt, sat(count101(32'h0000AAAA, 16), 2));
    bus_s.req = '0;

    // Single request, then no-hit and single-hit frames.
    frm[0] = 8'b10101010;
    run_frame(4'b0001, 0, 1'b0);
    frm[0] = 8'b11111111;
    run_frame(4'b0001, 0, 1'b0);
    frm[0] = 8'b00101000;
    run_frame(4'b0001, 0, 1'b0);

    // Reset during SHIFT: reset values next cycle, no done.
    @(negedge clk);
    bus.frame_data = {frm[3], frm[2], frm[1], frm[0]};
    bus.req = 4'b1111;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_gnt", bus.gnt, 0);
    check_eq("midrst_det_rst", det_rst, 1);
    check_eq("midrst_done", bus.done, 0);
    check_eq("midrst_hit", bus.hit_cnt, 0);
    reset = 1'b0;
    bus.req = '0;
    last_m = 3;
    hit_m = 0;

    // Rotation with every request held.
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) frm[i] = 8'($urandom);
      run_frame(4'b1111, 0, 1'b0);
    end

    // Granted requester drops its request mid-SHIFT.
    frm[2] = 8'b10110101;
    run_frame(4'b0100, 5, 1'b0);

    // Random requests and frames; non-granted requests wiggle mid-frame.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) frm[i] = 8'($urandom);
      run_frame(4'($urandom_range(1, 15)), 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
